// File: rtl/stream_fork_n.sv
// stream_fork_n: forks one valid/ready handshake into N_OUP handshakes, each output taking each beat once.
// Define STREAM_FORK_ASSERT_EN to compile simulation-only protocol assertions.
module stream_fork_n #(
    parameter int unsigned N_OUP = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [N_OUP-1:0] valid_o,
    input  logic [N_OUP-1:0] ready_i
);
    logic [N_OUP-1:0] sent_q;
    logic             all_done;

    assign valid_o  = {N_OUP{valid_i}} & ~sent_q;
    assign all_done = &(sent_q | ready_i);
    assign ready_o  = valid_i & all_done;

    // A completed input beat wipes the flags so the next beat is offered to every output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      sent_q <= '0;
        else if (ready_o) sent_q <= '0;
        else              sent_q <= sent_q | (valid_o & ready_i);
    end

`ifdef STREAM_FORK_ASSERT_EN
    if (N_OUP < 1) begin : g_bad_n_oup
        $error("stream_fork_n: N_OUP must be at least 1");
    end

    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_i && !ready_o |=> valid_i)
        else $error("%m: valid_i dropped before ready_o");

    a_single_take: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(|(valid_o & ready_i & sent_q)))
        else $error("%m: output handshook twice for one beat");
`endif
endmodule

// File: tb/tb_stream_fork_n.sv
// tb_stream_fork_n: checks forks of width 4, 3, 2 and 1 against a beat-counting reference model.
module tb_stream_fork_n;
    logic       clk;
    logic       rst_n;
    logic       vin [4];
    logic [3:0] rin [4];
    logic       rout[4];
    logic [3:0] vout[4];
    logic [3:0] vo4;
    logic [2:0] vo3;
    logic [1:0] vo2;
    logic       vo1;

    int n_cmp = 0;
    int n_bad = 0;
    int in_cnt[4];
    int acc[4][4];
    int hs_in[4];
    int hs_out[4][4];

    stream_fork_n #(.N_OUP(4)) u4 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vin[0]), .ready_o(rout[0]),
                                   .valid_o(vo4), .ready_i(rin[0]));
    stream_fork_n #(.N_OUP(3)) u3 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vin[1]), .ready_o(rout[1]),
                                   .valid_o(vo3), .ready_i(rin[1][2:0]));
    stream_fork_n #(.N_OUP(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vin[2]), .ready_o(rout[2]),
                                   .valid_o(vo2), .ready_i(rin[2][1:0]));
    stream_fork_n #(.N_OUP(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vin[3]), .ready_o(rout[3]),
                                   .valid_o(vo1), .ready_i(rin[3][0]));

    assign vout[0] = vo4;
    assign vout[1] = {1'b0, vo3};
    assign vout[2] = {2'b0, vo2};
    assign vout[3] = {3'b0, vo1};

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Output i still owes the current beat while it has accepted no more beats than the input has completed.
    function automatic bit exp_v(int d, int i);
        return i < 4 - d && vin[d] === 1'b1 && acc[d][i] == in_cnt[d];
    endfunction

    function automatic bit exp_r(int d);
        bit r = (vin[d] === 1'b1);
        for (int i = 0; i < 4 - d; i++)
            if (!(acc[d][i] > in_cnt[d] || rin[d][i])) r = 0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 4; i++)
                if (!rst_n) acc[d][i] <= in_cnt[d];
                else if (exp_v(d, i) && rin[d][i]) acc[d][i] <= acc[d][i] + 1;
            if (rst_n && exp_r(d)) in_cnt[d] <= in_cnt[d] + 1;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            logic [3:0] ev;
            ev = '0;
            for (int i = 0; i < 4; i++) ev[i] = exp_v(d, i);
            chk($sformatf("model_vo_n%0d", 4 - d), vout[d], ev);
            chk($sformatf("model_ro_n%0d", 4 - d), rout[d], exp_r(d));
            if (rst_n) begin
                if (vin[d] && rout[d]) hs_in[d]++;
                for (int i = 0; i < 4; i++) if (vout[d][i] && rin[d][i]) hs_out[d][i]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit hs;
        int beats;
        int cyc;
        rst_n = 0;
        for (int d = 0; d < 4; d++) begin
            vin[d] = 0;
            rin[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_vo4", vout[0], 4'b0000);
        chk("rst_ro4", rout[0], 1'b0);

        // Fast path: all outputs ready together
        @(posedge clk); #1 vin[0] = 1; rin[0] = 4'b1111;
        @(negedge clk); chk("fast_vo", vout[0], 4'b1111); chk("fast_ro", rout[0], 1'b1);
        @(posedge clk); #1 rin[0] = 4'b0000;
        @(negedge clk); chk("fast_next_vo", vout[0], 4'b1111); chk("fast_next_ro", rout[0], 1'b0);

        // Partial acceptance over three cycles
        @(posedge clk); #1 rin[0] = 4'b0001;
        @(negedge clk); chk("part0_vo", vout[0], 4'b1111); chk("part0_ro", rout[0], 1'b0);
        @(posedge clk); #1 rin[0] = 4'b0110;
        @(negedge clk); chk("part1_vo", vout[0], 4'b1110); chk("part1_ro", rout[0], 1'b0);
        @(posedge clk); #1 rin[0] = 4'b1000;
        @(negedge clk); chk("part2_vo", vout[0], 4'b1000); chk("part2_ro", rout[0], 1'b1);
        @(posedge clk); #1 rin[0] = 4'b1111;
        @(negedge clk); chk("part3_vo", vout[0], 4'b1111); chk("part3_ro", rout[0], 1'b1);
        @(posedge clk); #1 vin[0] = 0; rin[0] = 4'b0000;

        // Width 3 stalled for five cycles, then released
        vin[1] = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("stall_vo", vout[1], 4'b0111); chk("stall_ro", rout[1], 1'b0);
            @(posedge clk); #1;
        end
        rin[1] = 4'b0111;
        @(negedge clk); chk("release_ro", rout[1], 1'b1);
        @(posedge clk); #1 vin[1] = 0; rin[1] = 4'b0000;

        // Width 2: ready without valid, then accept and reset mid-beat
        rin[2] = 4'b0011;
        @(negedge clk); chk("novalid_vo", vout[2], 4'b0000); chk("novalid_ro", rout[2], 1'b0);
        @(posedge clk); #1 vin[2] = 1; rin[2] = 4'b0001;
        @(negedge clk); chk("noval_held_vo", vout[2], 4'b0011); chk("acc0_ro", rout[2], 1'b0);
        @(posedge clk); #1 rin[2] = 4'b0000;
        @(negedge clk); chk("acc0_vo", vout[2], 4'b0010);
        #2 rst_n = 0;
        #1 chk("rst_mid_vo", vout[2], 4'b0011); chk("rst_mid_ro", rout[2], 1'b0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); chk("post_rst_vo", vout[2], 4'b0011); chk("post_rst_ro", rout[2], 1'b0);
        @(posedge clk); #1 rin[2] = 4'b0011;
        @(negedge clk); chk("post_rst_done", rout[2], 1'b1);
        @(posedge clk); #1 vin[2] = 0; rin[2] = 4'b0000;

        // Random traffic on width 4, valid held until accepted
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); hs = vin[0] && rout[0];
            @(posedge clk); #1;
            if (!vin[0] || hs) vin[0] = ($urandom % 4) != 0;
            rin[0] = 4'($urandom);
        end
        @(negedge clk); hs = vin[0] && rout[0];
        if (vin[0] && !hs) begin
            @(posedge clk); #1 rin[0] = 4'b1111;
            @(negedge clk);
        end
        @(posedge clk); #1 vin[0] = 0; rin[0] = 4'b0000;

        // Width 1: random ready for 100 beats
        beats = 0;
        cyc = 0;
        while (beats < 100 && cyc < 2000) begin
            @(negedge clk);
            chk("n1_ro", rout[3], vin[3] & rin[3][0]);
            hs = vin[3] && rout[3];
            if (hs) beats++;
            @(posedge clk); #1;
            if (!vin[3] || hs) vin[3] = $urandom_range(0, 1);
            rin[3][0] = 1'($urandom_range(0, 1));
            cyc++;
        end
        if (beats < 100) begin
            n_cmp++; n_bad++;
            $display("FAIL n1_beats: got %0d beats expected 100", beats);
        end
        @(negedge clk); hs = vin[3] && rout[3];
        if (vin[3] && !hs) begin
            @(posedge clk); #1 rin[3] = 4'b0001;
            @(negedge clk);
        end
        @(posedge clk); #1 vin[3] = 0; rin[3] = 4'b0000;
        @(negedge clk);

        for (int d = 0; d < 4; d++) chk($sformatf("beats_n%0d", 4 - d), hs_in[d], in_cnt[d]);
        for (int i = 0; i < 4; i++) chk($sformatf("once_n4_o%0d", i), hs_out[0][i], hs_in[0]);
        chk("once_n1", hs_out[3][0], hs_in[3]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
